// File: rtl/slink_generic_rx_router_pkg.sv
// Shared definitions for the generic S-Link RX router.
//   - LONG_PKT_ID_MIN_DEFAULT : data IDs at or above this value are long packets
//   - state_e                 : router FSM encoding
//   - is_long_pkt()           : long/short packet classification of a data ID
package slink_generic_rx_router_pkg;

    localparam logic [7:0] LONG_PKT_ID_MIN_DEFAULT = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LONG = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    function automatic logic is_long_pkt(input logic [7:0] data_id,
                                         input logic [7:0] id_min);
        return (data_id >= id_min);
    endfunction

endpackage

// File: rtl/slink_demet_reset.sv
// Two-flop synchroniser for a level signal entering the clk domain.
// Ports:
//   clk     : destination clock
//   reset   : asynchronous active-high reset, output reads 0 while asserted
//   sig_in  : asynchronous level input
//   sig_out : synchronised level output
module slink_demet_reset (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic sig_out
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sig_in};
        end
    end

    assign sig_out = sync_q[1];

endmodule

// File: rtl/slink_rx_router_match.sv
// Combinational channel selector: masked data-ID compare against every channel
// followed by a lowest-index-wins priority encoder.
// Ports:
//   data_id_i : packet data ID
//   id_base_i : per-channel match value, channel i at [i*8 +: 8]
//   id_mask_i : per-channel compare mask, 1 = bit compared
//   win_o     : index of the lowest matching channel (0 when none match)
//   any_o     : at least one channel matched
module slink_rx_router_match #(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned IDXW         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic [7:0]                data_id_i,
    input  logic [NUM_CHANNELS*8-1:0] id_base_i,
    input  logic [NUM_CHANNELS*8-1:0] id_mask_i,
    output logic [IDXW-1:0]           win_o,
    output logic                      any_o
);

    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            // First hit latches; later (higher) indices cannot override it.
            if (!any_o &&
                ((data_id_i & id_mask_i[i*8 +: 8]) ==
                 (id_base_i[i*8 +: 8] & id_mask_i[i*8 +: 8]))) begin
                win_o = i[IDXW-1:0];
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/slink_generic_rx_router.sv
// S-Link RX application stream demultiplexer. Each packet is steered to one of
// NUM_CHANNELS channel interfaces by masked data-ID match; long packets lock the
// channel on the header and hold it for all payload beats. Unmatched packets are
// discarded and counted.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   enable                  : asynchronous enable, synchronised internally
//   cfg_ch_id_base/mask     : per-channel data-ID match value and compare mask
//   rx_sop, rx_data_id,
//   rx_word_count           : packet header from the link layer
//   rx_app_data, rx_valid,
//   rx_crc_corrupted        : payload beats from the link layer
//   rx_*_ch                 : per-channel outputs (ID/word count/data shared,
//                             strobes channel specific), all registered
//   rx_abort                : long packet truncated by a new header
//   rx_drop_count           : saturating count of unmatched packets
module slink_generic_rx_router
    import slink_generic_rx_router_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS      = 8,
    parameter int unsigned RX_APP_DATA_WIDTH = 64,
    parameter logic [7:0]  LONG_PKT_ID_MIN   = LONG_PKT_ID_MIN_DEFAULT
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic [NUM_CHANNELS*8-1:0]                 cfg_ch_id_base,
    input  logic [NUM_CHANNELS*8-1:0]                 cfg_ch_id_mask,
    input  logic                                      rx_sop,
    input  logic [7:0]                                rx_data_id,
    input  logic [15:0]                               rx_word_count,
    input  logic [RX_APP_DATA_WIDTH-1:0]              rx_app_data,
    input  logic                                      rx_valid,
    input  logic                                      rx_crc_corrupted,
    output logic [NUM_CHANNELS-1:0]                   rx_sop_ch,
    output logic [NUM_CHANNELS*8-1:0]                 rx_data_id_ch,
    output logic [NUM_CHANNELS*16-1:0]                rx_word_count_ch,
    output logic [NUM_CHANNELS*RX_APP_DATA_WIDTH-1:0] rx_app_data_ch,
    output logic [NUM_CHANNELS-1:0]                   rx_valid_ch,
    output logic [NUM_CHANNELS-1:0]                   rx_crc_corrupted_ch,
    output logic                                      rx_abort,
    output logic [15:0]                               rx_drop_count
);

    localparam int unsigned IDXW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [15:0] BPB  = 16'(RX_APP_DATA_WIDTH / 8);

    logic                         enable_sync;
    logic [IDXW-1:0]              win;
    logic                         any_match;

    state_e                       state_q,   state_d;
    logic [15:0]                  remain_q,  remain_d;
    logic [IDXW-1:0]              lock_q,    lock_d;
    logic [15:0]                  drop_q,    drop_d;
    logic [NUM_CHANNELS-1:0]      sop_q,     sop_d;
    logic [NUM_CHANNELS-1:0]      valid_q,   valid_d;
    logic [NUM_CHANNELS-1:0]      crc_q,     crc_d;
    logic                         abort_q,   abort_d;
    logic [7:0]                   id_q;
    logic [15:0]                  wc_q;
    logic [RX_APP_DATA_WIDTH-1:0] data_q;

    slink_demet_reset u_enable_sync (
        .clk     (clk),
        .reset   (reset),
        .sig_in  (enable),
        .sig_out (enable_sync)
    );

    slink_rx_router_match #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .IDXW         (IDXW)
    ) u_match (
        .data_id_i (rx_data_id),
        .id_base_i (cfg_ch_id_base),
        .id_mask_i (cfg_ch_id_mask),
        .win_o     (win),
        .any_o     (any_match)
    );

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        lock_d   = lock_q;
        drop_d   = drop_q;
        sop_d    = '0;
        valid_d  = '0;
        crc_d    = '0;
        abort_d  = 1'b0;

        if (!enable_sync) begin
            state_d  = ST_IDLE;
            remain_d = '0;
        end else if (rx_sop) begin
            // A header always restarts packet handling; any beat on the same
            // cycle belongs to nothing and is discarded.
            abort_d = (state_q != ST_IDLE);
            state_d = ST_IDLE;
            if (any_match) begin
                sop_d[win] = 1'b1;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 16'd1;
            end
            if (is_long_pkt(rx_data_id, LONG_PKT_ID_MIN) && (rx_word_count != '0)) begin
                remain_d = rx_word_count;
                if (any_match) begin
                    state_d = ST_LONG;
                    lock_d  = win;
                end else begin
                    state_d = ST_DROP;
                end
            end
        end else if (rx_valid && (state_q != ST_IDLE)) begin
            if (remain_q <= BPB) begin
                remain_d = '0;
                state_d  = ST_IDLE;
            end else begin
                remain_d = remain_q - BPB;
            end
            if (state_q == ST_LONG) begin
                valid_d[lock_q] = 1'b1;
                crc_d[lock_q]   = rx_crc_corrupted;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            lock_q   <= '0;
            drop_q   <= '0;
            sop_q    <= '0;
            valid_q  <= '0;
            crc_q    <= '0;
            abort_q  <= 1'b0;
            id_q     <= '0;
            wc_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            lock_q   <= lock_d;
            drop_q   <= drop_d;
            sop_q    <= sop_d;
            valid_q  <= valid_d;
            crc_q    <= crc_d;
            abort_q  <= abort_d;
            id_q     <= rx_data_id;
            wc_q     <= rx_word_count;
            data_q   <= rx_app_data;
        end
    end

    assign rx_sop_ch           = sop_q;
    assign rx_valid_ch         = valid_q;
    assign rx_crc_corrupted_ch = crc_q;
    assign rx_abort            = abort_q;
    assign rx_drop_count       = drop_q;
    assign rx_data_id_ch       = {NUM_CHANNELS{id_q}};
    assign rx_word_count_ch    = {NUM_CHANNELS{wc_q}};
    assign rx_app_data_ch      = {NUM_CHANNELS{data_q}};

endmodule

// File: tb/tb_slink_generic_rx_router.sv
module tb_slink_generic_rx_router;
    import slink_generic_rx_router_pkg::*;

    localparam int N = 4;
    localparam int W = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N*8-1:0]  cfg_ch_id_base;
    logic [N*8-1:0]  cfg_ch_id_mask;
    logic            rx_sop;
    logic [7:0]      rx_data_id;
    logic [15:0]     rx_word_count;
    logic [W-1:0]    rx_app_data;
    logic            rx_valid;
    logic            rx_crc_corrupted;
    logic [N-1:0]    rx_sop_ch;
    logic [N*8-1:0]  rx_data_id_ch;
    logic [N*16-1:0] rx_word_count_ch;
    logic [N*W-1:0]  rx_app_data_ch;
    logic [N-1:0]    rx_valid_ch;
    logic [N-1:0]    rx_crc_corrupted_ch;
    logic            rx_abort;
    logic [15:0]     rx_drop_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    slink_generic_rx_router #(
        .NUM_CHANNELS      (N),
        .RX_APP_DATA_WIDTH (W),
        .LONG_PKT_ID_MIN   (8'h20)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .cfg_ch_id_base      (cfg_ch_id_base),
        .cfg_ch_id_mask      (cfg_ch_id_mask),
        .rx_sop              (rx_sop),
        .rx_data_id          (rx_data_id),
        .rx_word_count       (rx_word_count),
        .rx_app_data         (rx_app_data),
        .rx_valid            (rx_valid),
        .rx_crc_corrupted    (rx_crc_corrupted),
        .rx_sop_ch           (rx_sop_ch),
        .rx_data_id_ch       (rx_data_id_ch),
        .rx_word_count_ch    (rx_word_count_ch),
        .rx_app_data_ch      (rx_app_data_ch),
        .rx_valid_ch         (rx_valid_ch),
        .rx_crc_corrupted_ch (rx_crc_corrupted_ch),
        .rx_abort            (rx_abort),
        .rx_drop_count       (rx_drop_count)
    );

    typedef struct {
        logic         sop;
        logic [7:0]   id;
        logic [15:0]  wc;
        logic         valid;
        logic [63:0]  data;
        logic         crc;
        logic [3:0]   e_sop;
        logic [3:0]   e_valid;
        logic [3:0]   e_crc;
        logic         e_abort;
        logic [15:0]  e_drop;
        logic         e_idle;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic sop, input logic [7:0] id, input logic [15:0] wc,
                       input logic valid, input logic [63:0] data, input logic crc,
                       input logic [3:0] e_sop, input logic [3:0] e_valid,
                       input logic [3:0] e_crc, input logic e_abort,
                       input logic [15:0] e_drop, input logic e_idle);
        vec_t v;
        v.sop = sop; v.id = id; v.wc = wc; v.valid = valid; v.data = data; v.crc = crc;
        v.e_sop = e_sop; v.e_valid = e_valid; v.e_crc = e_crc; v.e_abort = e_abort;
        v.e_drop = e_drop; v.e_idle = e_idle;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic sop, input logic [7:0] id, input logic [15:0] wc,
                         input logic valid, input logic [63:0] data, input logic crc);
        rx_sop = sop; rx_data_id = id; rx_word_count = wc;
        rx_valid = valid; rx_app_data = data; rx_crc_corrupted = crc;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sop"},   256'(rx_sop_ch), 256'(0));
        chk({tag, "_valid"}, 256'(rx_valid_ch), 256'(0));
        chk({tag, "_crc"},   256'(rx_crc_corrupted_ch), 256'(0));
        chk({tag, "_abort"}, 256'(rx_abort), 256'(0));
        chk({tag, "_drop"},  256'(rx_drop_count), 256'(0));
        chk({tag, "_id"},    256'(rx_data_id_ch), 256'(0));
        chk({tag, "_wc"},    256'(rx_word_count_ch), 256'(0));
        chk({tag, "_data"},  rx_app_data_ch, 256'(0));
        chk({tag, "_idle"},  256'(dut.state_q == ST_IDLE), 256'(1));
    endtask

    initial begin
        cfg_ch_id_base = {8'h40, 8'h40, 8'h30, 8'h00};
        cfg_ch_id_mask = {8'hFF, 8'hC0, 8'hF0, 8'hE0};
        reset = 1'b1;
        enable = 1'b1;
        drive(1'b0, 8'h00, 16'h0, 1'b0, 64'h0, 1'b0);

        //   sop id     wc      vld data                    crc  e_sop   e_val   e_crc   ab  drop  idle
        // long packet to ch1, 20 bytes = 3 beats, then a stray beat in IDLE
        add(1, 8'h31, 16'd20,   0, 64'h0,                   0, 4'b0010, 4'b0000, 4'b0000, 0, 16'd0, 0);
        add(0, 8'h00, 16'd0,    1, 64'hAAAA_0000_0000_0001, 0, 4'b0000, 4'b0010, 4'b0000, 0, 16'd0, 0);
        add(0, 8'h00, 16'd0,    1, 64'hBBBB_0000_0000_0002, 0, 4'b0000, 4'b0010, 4'b0000, 0, 16'd0, 0);
        add(0, 8'h00, 16'd0,    1, 64'hCCCC_0000_0000_0003, 0, 4'b0000, 4'b0010, 4'b0000, 0, 16'd0, 1);
        add(0, 8'h00, 16'd0,    1, 64'hDDDD_0000_0000_0004, 0, 4'b0000, 4'b0000, 4'b0000, 0, 16'd0, 1);
        // short packet to ch0
        add(1, 8'h05, 16'h1234, 0, 64'h0,                   0, 4'b0001, 4'b0000, 4'b0000, 0, 16'd0, 1);
        add(0, 8'h00, 16'd0,    1, 64'hEEEE_0000_0000_0005, 0, 4'b0000, 4'b0000, 4'b0000, 0, 16'd0, 1);
        // unmatched long packet, 16 bytes = 2 beats, CRC error on last is swallowed
        add(1, 8'hFF, 16'd16,   0, 64'h0,                   0, 4'b0000, 4'b0000, 4'b0000, 0, 16'd1, 0);
        add(0, 8'h00, 16'd0,    1, 64'h1111_0000_0000_0006, 0, 4'b0000, 4'b0000, 4'b0000, 0, 16'd1, 0);
        add(0, 8'h00, 16'd0,    1, 64'h2222_0000_0000_0007, 1, 4'b0000, 4'b0000, 4'b0000, 0, 16'd1, 1);
        // overlap ch2/ch3, lowest wins; long ID with wc 0 is header only
        add(1, 8'h40, 16'd0,    0, 64'h0,                   0, 4'b0100, 4'b0000, 4'b0000, 0, 16'd1, 1);
        // abort of ch1 packet by ch2 header with a concurrent (ignored) beat
        add(1, 8'h31, 16'd24,   0, 64'h0,                   0, 4'b0010, 4'b0000, 4'b0000, 0, 16'd1, 0);
        add(0, 8'h00, 16'd0,    1, 64'h3333_0000_0000_0008, 0, 4'b0000, 4'b0010, 4'b0000, 0, 16'd1, 0);
        add(1, 8'h45, 16'd8,    1, 64'h4444_0000_0000_0009, 0, 4'b0100, 4'b0000, 4'b0000, 1, 16'd1, 0);
        add(0, 8'h00, 16'd0,    1, 64'h5555_0000_0000_000A, 1, 4'b0000, 4'b0100, 4'b0100, 0, 16'd1, 1);
        // abort out of DROP
        add(1, 8'hFF, 16'd16,   0, 64'h0,                   0, 4'b0000, 4'b0000, 4'b0000, 0, 16'd2, 0);
        add(1, 8'h31, 16'd8,    1, 64'h6666_0000_0000_000B, 0, 4'b0010, 4'b0000, 4'b0000, 1, 16'd2, 0);
        add(0, 8'h00, 16'd0,    1, 64'h7777_0000_0000_000C, 0, 4'b0000, 4'b0010, 4'b0000, 0, 16'd2, 1);

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("v%0d", i);
            @(negedge clk);
            drive(vecs[i].sop, vecs[i].id, vecs[i].wc, vecs[i].valid, vecs[i].data, vecs[i].crc);
            @(posedge clk);
            #1;
            chk({t, "_sop"},   256'(rx_sop_ch), 256'(vecs[i].e_sop));
            chk({t, "_valid"}, 256'(rx_valid_ch), 256'(vecs[i].e_valid));
            chk({t, "_crc"},   256'(rx_crc_corrupted_ch), 256'(vecs[i].e_crc));
            chk({t, "_abort"}, 256'(rx_abort), 256'(vecs[i].e_abort));
            chk({t, "_drop"},  256'(rx_drop_count), 256'(vecs[i].e_drop));
            chk({t, "_idle"},  256'(dut.state_q == ST_IDLE), 256'(vecs[i].e_idle));
            chk({t, "_id"},    256'(rx_data_id_ch), 256'({N{vecs[i].id}}));
            chk({t, "_wc"},    256'(rx_word_count_ch), 256'({N{vecs[i].wc}}));
            chk({t, "_data"},  rx_app_data_ch, {N{vecs[i].data}});
        end

        // enable drop mid-packet: strobes cleared and FSM idle within 3 cycles
        @(negedge clk);
        drive(1'b1, 8'h31, 16'd64, 1'b0, 64'h0, 1'b0);
        @(posedge clk); #1;
        chk("en_sop", 256'(rx_sop_ch), 256'(4'b0010));
        @(negedge clk);
        drive(1'b0, 8'h00, 16'd0, 1'b1, 64'h8888_0000_0000_000D, 1'b0);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("en_valid", 256'(rx_valid_ch), 256'(0));
        chk("en_sop0",  256'(rx_sop_ch), 256'(0));
        chk("en_idle",  256'(dut.state_q == ST_IDLE), 256'(1));
        chk("en_drop",  256'(rx_drop_count), 256'(16'd2));
        @(negedge clk);
        drive(1'b0, 8'h00, 16'd0, 1'b0, 64'h0, 1'b0);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 8'h05, 16'h0042, 1'b0, 64'h0, 1'b0);
        @(posedge clk); #1;
        chk("reen_sop", 256'(rx_sop_ch), 256'(4'b0001));

        // reset mid-packet: everything back to zero immediately
        @(negedge clk);
        drive(1'b1, 8'h31, 16'd64, 1'b0, 64'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 16'd0, 1'b1, 64'h9999_0000_0000_000E, 1'b0);
        @(posedge clk); #1;
        chk("rst_pre_valid", 256'(rx_valid_ch), 256'(4'b0010));
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        drive(1'b0, 8'h00, 16'd0, 1'b0, 64'h0, 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
